mem_stage: RTL and testbench

//  RISC-V MEM stage plus MEM/WB pipeline register; sits between EX/MEM and wb_stage.

---
 rtl/mem_stage_pkg.sv | 40 ++++
 rtl/mem_load_align.sv | 31 +++
 rtl/mem_stage.sv | 147 ++++++++++++++
 tb/tb_mem_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: control-vector layout, RV32I
// load/store funct3 codes, exception cause codes, FSM states and the
// alignment rule used to decide whether an access may be issued.
package mem_stage_pkg;

  localparam int unsigned CONTROL_SIGNALS_WIDTH = 8;

  // Bit positions inside the control vector
  localparam int unsigned CTRL_MEM_READ  = 0;
  localparam int unsigned CTRL_MEM_WRITE = 1;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    EXC_NONE        = 2'b00,
    EXC_MISALIGN    = 2'b01,
    EXC_BUS_TIMEOUT = 2'b10
  } exc_cause_t;

  typedef enum logic {
    MEM_ST_IDLE = 1'b0,
    MEM_ST_BUSY = 1'b1
  } mem_state_t;

  // Halfwords need addr[0]==0, words need addr[1:0]==0. The unused size
  // encoding 2'b11 is accessed as a word but never traps.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    return ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
           ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load alignment: selects the addressed byte/halfword out of the 32-bit
// memory word and sign- or zero-extends it.
//   rdata     in  32  raw word from data memory
//   addr_lo   in  2   byte offset within the word
//   funct3    in  3   load size/sign encoding
//   load_data out 32  aligned, extended load value
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = rdata[{addr_lo, 3'b000} +: 8];
    lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_LBU:  load_data = {24'h000000, lane_byte};
      F3_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      F3_LHU:  load_data = {16'h0000, lane_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RISC-V MEM stage with MEM/WB pipeline register. Issues req/ack data
// memory accesses, stalls the pipe while an access is outstanding, aligns
// loads, builds store byte lanes and traps misaligned or timed-out accesses.
//   clk, rst                  clock, synchronous active-high reset
//   ex_mem_*                  instruction held in EX/MEM
//   dmem_req/we/addr/wdata/wstrb, dmem_rdata/ack   data memory port
//   mem_stall                 hold EX/MEM and PC upstream
//   mem_wb_*                  registered results for the writeback stage
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ex_mem_valid,
  input  logic [31:0]                      ex_mem_alu_result,
  input  logic [31:0]                      ex_mem_rs2_data,
  input  logic [2:0]                       ex_mem_funct3,
  input  logic [CONTROL_SIGNALS_WIDTH-1:0] ex_mem_control_signals,
  output logic                             dmem_req,
  output logic                             dmem_we,
  output logic [31:0]                      dmem_addr,
  output logic [31:0]                      dmem_wdata,
  output logic [3:0]                       dmem_wstrb,
  input  logic [31:0]                      dmem_rdata,
  input  logic                             dmem_ack,
  output logic                             mem_stall,
  output logic                             mem_wb_valid,
  output logic [31:0]                      mem_wb_alu_result,
  output logic [31:0]                      mem_wb_mem_data,
  output logic [CONTROL_SIGNALS_WIDTH-1:0] mem_wb_control_signals,
  output logic [1:0]                       mem_wb_exc_cause
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t       state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;

  logic        is_read, is_store, access, misaligned, timeout_now;
  logic [3:0]  lane_strb;
  logic [31:0] load_data;

  assign is_read     = ex_mem_control_signals[CTRL_MEM_READ];
  assign is_store    = ex_mem_control_signals[CTRL_MEM_WRITE];
  assign access      = ex_mem_valid & (is_read | is_store);
  assign misaligned  = access & is_misaligned(ex_mem_funct3, ex_mem_alu_result[1:0]);
  assign timeout_now = (state == MEM_ST_BUSY) && (wait_cnt == CNT_LAST);

  // All port fields derive only from EX/MEM, which upstream holds while
  // stalled, so they stay stable for the whole request.
  assign dmem_req   = access & ~misaligned & ~rst;
  assign dmem_we    = is_store;
  assign dmem_addr  = {ex_mem_alu_result[31:2], 2'b00};
  assign dmem_wstrb = is_store ? lane_strb : '0;
  assign mem_stall  = dmem_req & ~dmem_ack & ~timeout_now;

  always_comb begin
    case (ex_mem_funct3[1:0])
      2'b00: begin
        dmem_wdata = {4{ex_mem_rs2_data[7:0]}};
        lane_strb  = 4'b0001 << ex_mem_alu_result[1:0];
      end
      2'b01: begin
        dmem_wdata = {2{ex_mem_rs2_data[15:0]}};
        lane_strb  = 4'b0011 << {ex_mem_alu_result[1], 1'b0};
      end
      default: begin
        dmem_wdata = ex_mem_rs2_data;
        lane_strb  = 4'b1111;
      end
    endcase
  end

  mem_load_align u_load_align (
    .rdata     (dmem_rdata),
    .addr_lo   (ex_mem_alu_result[1:0]),
    .funct3    (ex_mem_funct3),
    .load_data (load_data)
  );

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      MEM_ST_IDLE: begin
        if (dmem_req && !dmem_ack) begin
          state_next    = MEM_ST_BUSY;
          wait_cnt_next = CNT_W'(1);
        end
      end
      MEM_ST_BUSY: begin
        if (dmem_ack || timeout_now) begin
          state_next    = MEM_ST_IDLE;
          wait_cnt_next = '0;
        end else begin
          wait_cnt_next = wait_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next    = MEM_ST_IDLE;
        wait_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= MEM_ST_IDLE;
      wait_cnt               <= '0;
      mem_wb_valid           <= 1'b0;
      mem_wb_alu_result      <= '0;
      mem_wb_mem_data        <= '0;
      mem_wb_control_signals <= '0;
      mem_wb_exc_cause       <= EXC_NONE;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (mem_stall) begin
        mem_wb_valid           <= 1'b0;
        mem_wb_control_signals <= '0;
        mem_wb_exc_cause       <= EXC_NONE;
      end else if (misaligned) begin
        mem_wb_valid           <= 1'b0;
        mem_wb_control_signals <= '0;
        mem_wb_exc_cause       <= EXC_MISALIGN;
        mem_wb_alu_result      <= ex_mem_alu_result;
        mem_wb_mem_data        <= '0;
      end else if (timeout_now) begin
        mem_wb_valid           <= 1'b0;
        mem_wb_control_signals <= '0;
        mem_wb_exc_cause       <= EXC_BUS_TIMEOUT;
        mem_wb_alu_result      <= ex_mem_alu_result;
        mem_wb_mem_data        <= '0;
      end else begin
        mem_wb_valid           <= ex_mem_valid;
        mem_wb_control_signals <= ex_mem_control_signals;
        mem_wb_exc_cause       <= EXC_NONE;
        mem_wb_alu_result      <= ex_mem_alu_result;
        mem_wb_mem_data        <= (dmem_req && dmem_ack && !is_store) ? load_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int unsigned CSW = CONTROL_SIGNALS_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           ex_mem_valid;
  logic [31:0]    ex_mem_alu_result, ex_mem_rs2_data, dmem_rdata;
  logic [2:0]     ex_mem_funct3;
  logic [CSW-1:0] ex_mem_control_signals;
  logic           dmem_ack;

  // a_*: TIMEOUT_CYCLES=16 instance, b_*: TIMEOUT_CYCLES=4 instance
  logic           a_req, a_we, a_stall, a_wbv, b_req, b_we, b_stall, b_wbv;
  logic [31:0]    a_addr, a_wdata, a_wba, a_wbd, b_addr, b_wdata, b_wba, b_wbd;
  logic [3:0]     a_strb, b_strb;
  logic [CSW-1:0] a_wbc, b_wbc;
  logic [1:0]     a_cause, b_cause;

  mem_stage #(.TIMEOUT_CYCLES(16)) u_dut (
    .clk(clk), .rst(rst), .ex_mem_valid(ex_mem_valid),
    .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_rs2_data(ex_mem_rs2_data),
    .ex_mem_funct3(ex_mem_funct3), .ex_mem_control_signals(ex_mem_control_signals),
    .dmem_req(a_req), .dmem_we(a_we), .dmem_addr(a_addr), .dmem_wdata(a_wdata),
    .dmem_wstrb(a_strb), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_stall(a_stall), .mem_wb_valid(a_wbv), .mem_wb_alu_result(a_wba),
    .mem_wb_mem_data(a_wbd), .mem_wb_control_signals(a_wbc), .mem_wb_exc_cause(a_cause));

  mem_stage #(.TIMEOUT_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .ex_mem_valid(ex_mem_valid),
    .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_rs2_data(ex_mem_rs2_data),
    .ex_mem_funct3(ex_mem_funct3), .ex_mem_control_signals(ex_mem_control_signals),
    .dmem_req(b_req), .dmem_we(b_we), .dmem_addr(b_addr), .dmem_wdata(b_wdata),
    .dmem_wstrb(b_strb), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_stall(b_stall), .mem_wb_valid(b_wbv), .mem_wb_alu_result(b_wba),
    .mem_wb_mem_data(b_wbd), .mem_wb_control_signals(b_wbc), .mem_wb_exc_cause(b_cause));

  bit sel4 = 1'b0;
  logic           c_req, c_we, c_stall, c_wbv;
  logic [31:0]    c_addr, c_wdata, c_wba, c_wbd;
  logic [3:0]     c_strb;
  logic [CSW-1:0] c_wbc;
  logic [1:0]     c_cause;
  assign c_req   = sel4 ? b_req   : a_req;
  assign c_we    = sel4 ? b_we    : a_we;
  assign c_stall = sel4 ? b_stall : a_stall;
  assign c_wbv   = sel4 ? b_wbv   : a_wbv;
  assign c_addr  = sel4 ? b_addr  : a_addr;
  assign c_wdata = sel4 ? b_wdata : a_wdata;
  assign c_wba   = sel4 ? b_wba   : a_wba;
  assign c_wbd   = sel4 ? b_wbd   : a_wbd;
  assign c_strb  = sel4 ? b_strb  : a_strb;
  assign c_wbc   = sel4 ? b_wbc   : a_wbc;
  assign c_cause = sel4 ? b_cause : a_cause;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    bit             sel4;
    bit             v;
    logic [CSW-1:0] ctrl;
    logic [31:0]    addr, rs2, rdata;
    logic [2:0]     f3;
    int             delay;     // cycles until ack; 99 = never
    bit             e_req;
    int             e_stall;
    logic [1:0]     e_cause;
    logic [31:0]    e_data, e_wdata;
    logic [3:0]     e_strb;
  } vec_t;

  function automatic vec_t mk(bit s4, bit v, logic [CSW-1:0] ctrl, logic [31:0] addr,
                              logic [31:0] rs2, logic [2:0] f3, logic [31:0] rdata, int delay,
                              bit e_req, int e_stall, logic [1:0] e_cause, logic [31:0] e_data,
                              logic [31:0] e_wdata, logic [3:0] e_strb);
    vec_t t;
    t.sel4 = s4; t.v = v; t.ctrl = ctrl; t.addr = addr; t.rs2 = rs2; t.f3 = f3;
    t.rdata = rdata; t.delay = delay; t.e_req = e_req; t.e_stall = e_stall;
    t.e_cause = e_cause; t.e_data = e_data; t.e_wdata = e_wdata; t.e_strb = e_strb;
    return t;
  endfunction

  // Reference model: derives the expected behaviour from access size,
  // byte offset and ack delay with plain arithmetic.
  function automatic vec_t model(input vec_t t);
    vec_t r = t;
    int tl   = t.sel4 ? 4 : 16;
    int sz   = (t.f3[1:0] == 2'b00) ? 1 : (t.f3[1:0] == 2'b01) ? 2 : 4;
    int lane = int'(t.addr[1:0]);
    int off  = (sz == 1) ? lane : (sz == 2) ? (lane & 2) : 0;
    bit acc  = t.v && (t.ctrl[CTRL_MEM_READ] || t.ctrl[CTRL_MEM_WRITE]);
    bit st   = t.ctrl[CTRL_MEM_WRITE];
    bit mis  = acc && (t.f3[1:0] != 2'b11) && ((lane % sz) != 0);
    bit tmo;
    logic [31:0] mask, raw;
    logic [7:0]  strb8;
    r.e_req   = acc && !mis;
    tmo       = r.e_req && (t.delay >= tl - 1);
    r.e_stall = !r.e_req ? 0 : tmo ? tl - 1 : t.delay;
    r.e_cause = mis ? 2'd1 : tmo ? 2'd2 : 2'd0;
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
    raw  = (t.rdata >> (8 * off)) & mask;
    if (!t.f3[2] && sz < 4 && raw[8 * sz - 1]) raw = raw | ~mask;
    r.e_data  = (r.e_req && !st && !tmo) ? raw : 32'h0;
    r.e_wdata = (sz == 1) ? {24'h0, t.rs2[7:0]} * 32'h0101_0101 :
                (sz == 2) ? {16'h0, t.rs2[15:0]} * 32'h0001_0001 : t.rs2;
    strb8    = 8'((32'h1 << sz) - 32'h1) << off;
    r.e_strb = st ? strb8[3:0] : 4'h0;
    return r;
  endfunction

  task automatic apply(input vec_t t, input string tag);
    int cyc = 0;
    bit done = 1'b0;
    @(negedge clk);
    sel4 = t.sel4;
    ex_mem_valid = t.v; ex_mem_control_signals = t.ctrl; ex_mem_alu_result = t.addr;
    ex_mem_rs2_data = t.rs2; ex_mem_funct3 = t.f3;
    while (!done) begin
      dmem_ack   = (cyc == t.delay);
      dmem_rdata = dmem_ack ? t.rdata : $urandom;
      #1;
      chk({tag, " req"}, 32'(c_req), 32'(t.e_req));
      if (t.e_req) begin
        chk({tag, " addr"}, c_addr, t.addr & 32'hFFFF_FFFC);
        chk({tag, " we"}, 32'(c_we), 32'(t.ctrl[CTRL_MEM_WRITE]));
        chk({tag, " wstrb"}, 32'(c_strb), 32'(t.e_strb));
        if (t.ctrl[CTRL_MEM_WRITE]) chk({tag, " wdata"}, c_wdata, t.e_wdata);
      end
      chk({tag, " stall"}, 32'(c_stall), 32'(cyc < t.e_stall));
      @(posedge clk); #1;
      if (cyc < t.e_stall) begin
        chk({tag, " bubble valid"}, 32'(c_wbv), 32'd0);
        chk({tag, " bubble cause"}, 32'(c_cause), 32'd0);
        cyc++;
        @(negedge clk);
      end else begin
        chk({tag, " wb valid"}, 32'(c_wbv), (t.e_cause == 2'd0) ? 32'(t.v) : 32'd0);
        chk({tag, " wb cause"}, 32'(c_cause), 32'(t.e_cause));
        chk({tag, " wb alu"}, c_wba, t.addr);
        chk({tag, " wb ctrl"}, 32'(c_wbc), (t.e_cause == 2'd0) ? 32'(t.ctrl) : 32'd0);
        if (t.e_cause == 2'd0) chk({tag, " wb data"}, c_wbd, t.e_data);
        done = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ex_mem_valid = 1'b0; dmem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  localparam logic [CSW-1:0] RD = CSW'(1) << CTRL_MEM_READ;
  localparam logic [CSW-1:0] WR = CSW'(1) << CTRL_MEM_WRITE;

  vec_t tbl[$];
  vec_t rv;

  initial begin
    rst = 1'b1; ex_mem_valid = 1'b0; ex_mem_alu_result = '0; ex_mem_rs2_data = '0;
    ex_mem_funct3 = '0; ex_mem_control_signals = '0; dmem_rdata = '0; dmem_ack = 1'b0;

    //          sel v  ctrl   addr          rs2           f3      rdata         dly req stl cause data          wdata         strb
    tbl.push_back(mk(0, 1, RD,    32'h100, 32'h0,        3'b010, 32'hDEADBEEF, 0,  1,  0,  2'd0, 32'hDEADBEEF, 32'h0,        4'b0000));
    tbl.push_back(mk(0, 1, RD,    32'h103, 32'h0,        3'b000, 32'h80FFFF00, 3,  1,  3,  2'd0, 32'hFFFFFF80, 32'h0,        4'b0000));
    tbl.push_back(mk(0, 1, RD,    32'h103, 32'h0,        3'b100, 32'h80FFFF00, 3,  1,  3,  2'd0, 32'h00000080, 32'h0,        4'b0000));
    tbl.push_back(mk(0, 1, WR,    32'h202, 32'h1234ABCD, 3'b001, 32'h0,        0,  1,  0,  2'd0, 32'h0,        32'hABCDABCD, 4'b1100));
    tbl.push_back(mk(0, 1, RD,    32'h102, 32'h0,        3'b010, 32'h0,        0,  0,  0,  2'd1, 32'h0,        32'h0,        4'b0000));
    tbl.push_back(mk(0, 1, 8'h80, 32'h55,  32'h0,        3'b010, 32'hFFFFFFFF, 0,  0,  0,  2'd0, 32'h0,        32'h0,        4'b0000));
    tbl.push_back(mk(0, 1, WR,    32'h3,   32'h55,       3'b000, 32'h0,        1,  1,  1,  2'd0, 32'h0,        32'h55555555, 4'b1000));
    tbl.push_back(mk(0, 1, RD,    32'h102, 32'h0,        3'b001, 32'h80017FFF, 1,  1,  1,  2'd0, 32'hFFFF8001, 32'h0,        4'b0000));
    tbl.push_back(mk(0, 1, RD,    32'h101, 32'h0,        3'b011, 32'h12345678, 0,  1,  0,  2'd0, 32'h12345678, 32'h0,        4'b0000));
    tbl.push_back(mk(0, 0, RD,    32'h400, 32'h0,        3'b010, 32'h0,        0,  0,  0,  2'd0, 32'h0,        32'h0,        4'b0000));
    tbl.push_back(mk(0, 1, WR,    32'h201, 32'h0,        3'b001, 32'h0,        0,  0,  0,  2'd1, 32'h0,        32'h0,        4'b0000));
    tbl.push_back(mk(0, 1, WR,    32'h300, 32'hCAFEF00D, 3'b010, 32'h0,        2,  1,  2,  2'd0, 32'h0,        32'hCAFEF00D, 4'b1111));

    // reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst req", 32'(a_req), 32'd0);
    chk("rst stall", 32'(a_stall), 32'd0);
    chk("rst wb valid", 32'(a_wbv), 32'd0);
    chk("rst wb alu", a_wba, 32'd0);
    chk("rst wb data", a_wbd, 32'd0);
    chk("rst wb ctrl", 32'(a_wbc), 32'd0);
    chk("rst wb cause", 32'(a_cause), 32'd0);
    @(negedge clk); rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // bus timeout with TIMEOUT_CYCLES=4: 3 stall cycles, trap in the 4th
    do_reset();
    apply(mk(1, 1, RD, 32'h500, 32'h0, 3'b010, 32'h0, 99, 1, 3, 2'd2, 32'h0, 32'h0, 4'b0000), "timeout");

    // reset in the second cycle of a pending load abandons it
    do_reset();
    @(negedge clk);
    sel4 = 1'b0; ex_mem_valid = 1'b1; ex_mem_control_signals = RD;
    ex_mem_alu_result = 32'h600; ex_mem_funct3 = 3'b010; dmem_ack = 1'b0;
    #1 chk("rstpend stall c1", 32'(c_stall), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rstpend req", 32'(c_req), 32'd0);
    chk("rstpend stall", 32'(c_stall), 32'd0);
    @(posedge clk); #1;
    chk("rstpend wb valid", 32'(c_wbv), 32'd0);
    chk("rstpend wb alu", c_wba, 32'd0);
    chk("rstpend wb data", c_wbd, 32'd0);
    chk("rstpend wb ctrl", 32'(c_wbc), 32'd0);
    chk("rstpend wb cause", 32'(c_cause), 32'd0);
    @(negedge clk); rst = 1'b0; ex_mem_valid = 1'b0;
    apply(mk(0, 1, RD, 32'h604, 32'h0, 3'b010, 32'h01020304, 1, 1, 1, 2'd0, 32'h01020304, 32'h0, 4'b0000), "after rst");

    // randomized transactions against the reference model
    for (int n = 0; n < 60; n++) begin
      int kind = $urandom_range(0, 2);
      rv.v     = ($urandom_range(0, 9) != 0);
      rv.ctrl  = CSW'($urandom) & ~(RD | WR);
      rv.ctrl  = rv.ctrl | ((kind == 0) ? RD : (kind == 1) ? WR : '0);
      rv.addr  = $urandom;
      rv.rs2   = $urandom;
      rv.rdata = $urandom;
      rv.f3    = 3'($urandom_range(0, 7));
      rv.delay = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(0, 2);
      rv.sel4  = (rv.delay == 99);
      rv = model(rv);
      apply(rv, $sformatf("rnd%0d", n));
      if (rv.delay == 99) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
